// File: rtl/reaction_timer.sv
// reaction_timer: reaction-time measurement for a start-light game.
// A synchronised, edge-detected player key is timed against a free
// 1 ms tick after the start light comes on; the result is kept as four
// BCD digits. Optional best-time tracking is compiled in with the
// REACTION_BEST_EN macro; without it best_bcd is tied to zero.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | after reset, waiting for start
// ARMED    | round armed, waiting for the start light (go)
// TIMING   | start light seen, counting ms ticks until a press
// DONE     | valid reaction time held in time_bcd
// FOUL     | press arrived before the start light
// TOUT     | no press before TIMEOUT_MS, time_bcd holds the limit
module reaction_timer #(
    parameter int CLK_PER_MS = 50000,
    parameter int TIMEOUT_MS = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        go,
    input  logic        btn_n,
    output logic [2:0]  state_o,
    output logic [15:0] time_bcd,
    output logic        done,
    output logic        foul,
    output logic        timeout,
    output logic [15:0] best_bcd
);

    localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(CLK_PER_MS - 1);
    localparam logic [15:0] TIMEOUT_BCD = {4'(TIMEOUT_MS / 1000),
                                           4'((TIMEOUT_MS / 100) % 10),
                                           4'((TIMEOUT_MS / 10) % 10),
                                           4'(TIMEOUT_MS % 10)};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_TIMING = 3'd2,
        S_DONE   = 3'd3,
        S_FOUL   = 3'd4,
        S_TOUT   = 3'd5
    } state_t;

    // Four-digit BCD increment with decimal carry; 9999 wraps to 0000,
    // which never happens in practice because the timeout stops first.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    state_t          r_state;
    logic [15:0]     r_time;
    logic [CW-1:0]   r_cnt;
    logic            r_done;
    logic            r_foul;
    logic            r_tout;
    logic            r_btn_s1;
    logic            r_btn_s2;
    logic            r_btn_d;
    logic            r_press;
    logic            w_tick;
    logic [15:0]     w_time_inc;

    assign w_tick     = (r_state == S_TIMING) && (r_cnt == TICK_LAST);
    assign w_time_inc = bcd_inc(r_time);

    // Key synchroniser and registered falling-edge detector; the press
    // pulse appears three edges after the key goes low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_s1 <= 1'b1;
            r_btn_s2 <= 1'b1;
            r_btn_d  <= 1'b1;
            r_press  <= 1'b0;
        end else begin
            r_btn_s1 <= btn_n;
            r_btn_s2 <= r_btn_s1;
            r_btn_d  <= r_btn_s2;
            r_press  <= r_btn_d & ~r_btn_s2;
        end
    end

    // Round FSM with ms tick counter, BCD time and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_time  <= 16'h0000;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_foul  <= 1'b0;
            r_tout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_FOUL, S_TOUT: begin
                    if (start) begin
                        r_state <= S_ARMED;
                        r_time  <= 16'h0000;
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                        r_foul  <= 1'b0;
                        r_tout  <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (r_press) begin
                        r_state <= S_FOUL;
                        r_foul  <= 1'b1;
                    end else if (go) begin
                        r_state <= S_TIMING;
                        r_cnt   <= '0;
                    end
                end
                S_TIMING: begin
                    // A press wins over a coincident tick, freezing the time.
                    if (r_press) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (w_tick) begin
                        r_cnt  <= '0;
                        r_time <= w_time_inc;
                        if (w_time_inc == TIMEOUT_BCD) begin
                            r_state <= S_TOUT;
                            r_tout  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_foul  <= 1'b0;
                    r_tout  <= 1'b0;
                end
            endcase
        end
    end

`ifdef REACTION_BEST_EN
    logic [15:0] r_best;

    // Best time: BCD digits order the same as the value, so a plain
    // unsigned compare picks the minimum. Loads on the edge done rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_best <= 16'h9999;
        end else if ((r_state == S_TIMING) && r_press && (r_time < r_best)) begin
            r_best <= r_time;
        end
    end

    assign best_bcd = r_best;
`else
    assign best_bcd = 16'h0000;
`endif

    assign state_o  = r_state;
    assign time_bcd = r_time;
    assign done     = r_done;
    assign foul     = r_foul;
    assign timeout  = r_tout;

endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: directed plus randomised rounds on a small
// configuration (4 clk per ms, 20 ms limit) and a long run on a second
// instance (2 clk per ms, 9999 ms limit) to cross the 0999->1000 carry.
// Expected results come from an arithmetic model of round timing.
module tb_reaction_timer;

    localparam int CPM = 4;
    localparam int TO  = 20;
    localparam int BIG_CPM = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, go, btn_n;
    logic [2:0]  state_o;
    logic [15:0] time_bcd, best_bcd;
    logic        done, foul, timeout;

    logic        b_start, b_go, b_btn_n;
    logic [2:0]  b_state;
    logic [15:0] b_time, b_best;
    logic        b_done, b_foul, b_timeout;

    int n_pass  = 0;
    int n_total = 0;
    int best_ms = 9999;

    reaction_timer #(.CLK_PER_MS(CPM), .TIMEOUT_MS(TO)) u_dut (
        .clk(clk), .rst(rst), .start(start), .go(go), .btn_n(btn_n),
        .state_o(state_o), .time_bcd(time_bcd), .done(done), .foul(foul),
        .timeout(timeout), .best_bcd(best_bcd)
    );

    reaction_timer #(.CLK_PER_MS(BIG_CPM), .TIMEOUT_MS(9999)) u_big (
        .clk(clk), .rst(rst), .start(b_start), .go(b_go), .btn_n(b_btn_n),
        .state_o(b_state), .time_bcd(b_time), .done(b_done), .foul(b_foul),
        .timeout(b_timeout), .best_bcd(b_best)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] exp_best();
`ifdef REACTION_BEST_EN
        return to_bcd(best_ms);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // One round. Go is raised, then the key drops w cycles after TIMING
    // entry; the FSM sees the press w+3 edges after entry, and every tick
    // strictly before that edge counts unless the limit is hit first.
    task automatic run_round(input string tag, input int pre, input int w,
                             input bit do_foul, input bit poke);
        int d, ticks, wait_n;
        pulse_start();
        chk({tag, "_armed"}, state_o, 3'd1);
        if (do_foul) begin
            cycles(pre);
            btn_n = 1'b0;
            cycles(5);
            chk({tag, "_foul"}, foul, 1'b1);
            chk({tag, "_fstate"}, state_o, 3'd4);
            chk({tag, "_ftime"}, time_bcd, 16'h0000);
            chk({tag, "_fflags"}, {done, timeout}, 2'b00);
            chk({tag, "_fbest"}, best_bcd, exp_best());
        end else begin
            cycles(pre);
            @(negedge clk) go = 1'b1;
            for (int k = 1; k <= w; k++) begin
                @(negedge clk);
                if (poke && k == 2) begin
                    start = 1'b1;
                    go    = 1'b0;
                end
                if (poke && k == 3) start = 1'b0;
            end
            btn_n  = 1'b0;
            wait_n = (w + 5 > CPM * TO + 5) ? 5 : (CPM * TO + 5 - w);
            cycles(wait_n);
            d     = w + 3;
            ticks = (d - 1) / CPM;
            if (ticks >= TO) begin
                chk({tag, "_tout"}, {done, foul, timeout}, 3'b001);
                chk({tag, "_tstate"}, state_o, 3'd5);
                chk({tag, "_ttime"}, time_bcd, to_bcd(TO));
            end else begin
                if (ticks < best_ms) best_ms = ticks;
                chk({tag, "_done"}, {done, foul, timeout}, 3'b100);
                chk({tag, "_dstate"}, state_o, 3'd3);
                chk({tag, "_dtime"}, time_bcd, to_bcd(ticks));
            end
            chk({tag, "_best"}, best_bcd, exp_best());
        end
        btn_n = 1'b1;
        go    = 1'b0;
        cycles(4);
    endtask

    initial begin
        int pre, w;
        bit fl, pk;
        rst = 1'b1; start = 1'b0; go = 1'b0; btn_n = 1'b1;
        b_start = 1'b0; b_go = 1'b0; b_btn_n = 1'b1;
        cycles(3);
        chk("rst_state", state_o, 3'd0);
        chk("rst_time", time_bcd, 16'h0000);
        chk("rst_flags", {done, foul, timeout}, 3'b000);
        chk("rst_best", best_bcd, exp_best());
        @(negedge clk) rst = 1'b0;
        cycles(2);

        run_round("press30", 2, 30, 1'b0, 1'b0);
        run_round("foul", 3, 0, 1'b1, 1'b0);

        // Timeout lands exactly 80 edges after TIMING entry.
        pulse_start();
        cycles(2);
        @(negedge clk) go = 1'b1;
        cycles(80);
        chk("tout_early", {state_o, timeout}, {3'd2, 1'b0});
        chk("tout_early_time", time_bcd, 16'h0019);
        cycles(1);
        chk("tout_edge", {state_o, timeout, done, foul}, {3'd5, 3'b100});
        chk("tout_time", time_bcd, 16'h0020);
        chk("tout_best", best_bcd, exp_best());
        go = 1'b0;
        cycles(3);

        run_round("r12", 1, 46, 1'b0, 1'b0);
        run_round("r05", 1, 18, 1'b0, 1'b0);
        run_round("tick3", 2, 9, 1'b0, 1'b0);
        run_round("poke", 2, 25, 1'b0, 1'b1);

        for (int r = 0; r < 20; r++) begin
            pre = int'($urandom_range(5, 1));
            w   = int'($urandom_range(100, 4));
            fl  = ($urandom_range(4, 0) == 0);
            pk  = ($urandom_range(2, 0) == 0);
            run_round($sformatf("rnd%0d", r), pre, w, fl, pk);
        end

        // Reset in the middle of a round aborts it with nothing flagged.
        pulse_start();
        @(negedge clk) go = 1'b1;
        cycles(10);
        rst = 1'b1;
        cycles(1);
        best_ms = 9999;
        chk("mid_rst_state", state_o, 3'd0);
        chk("mid_rst_flags", {done, foul, timeout}, 3'b000);
        chk("mid_rst_time", time_bcd, 16'h0000);
        chk("mid_rst_best", best_bcd, exp_best());
        rst = 1'b0;
        go  = 1'b0;
        cycles(3);

        // Long run on the second instance across the thousands carry.
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        @(negedge clk) b_go = 1'b1;
        cycles(2000);
        chk("big_0999", b_time, 16'h0999);
        cycles(1);
        chk("big_1000", b_time, 16'h1000);
        cycles(197);
        b_btn_n = 1'b0;
        cycles(5);
        chk("big_1100", b_time, 16'h1100);
        chk("big_flags", {b_state, b_done, b_foul, b_timeout}, {3'd3, 3'b100});
`ifdef REACTION_BEST_EN
        chk("big_best", b_best, 16'h1100);
`else
        chk("big_best", b_best, 16'h0000);
`endif
        b_btn_n = 1'b1;
        b_go    = 1'b0;
        cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter CLK_PER_MS, default 50000: clk cycles per 1 ms tick; legal range 2..2^20.
REQ-002 Parameter TIMEOUT_MS, default 9999: reaction-time limit in ms; legal range 1..9999.
REQ-003 clk  input  1  system clock (CLOCK_50); all logic on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 start  input  1  one-cycle pulse; arms a new round.
REQ-006 go  input  1  level from the start-delay stage; high means the start light is on.
REQ-007 btn_n  input  1  raw player key, active-low, asynchronous to clk.
REQ-008 state_o  output  3  current FSM state encoding.
REQ-009 time_bcd  output  16  reaction time, four BCD digits, [15:12] is thousands.
REQ-010 done  output  1  high while a valid reaction time is held.
REQ-011 foul  output  1  high while a false start is held.
REQ-012 timeout  output  1  high while a timeout is held.
REQ-013 best_bcd  output  16  best (minimum) valid time, four BCD digits.

Function
REQ-014 The block shall pass btn_n through a 2-flop synchronizer, then through a registered falling-edge detector that produces a one-cycle press pulse.
REQ-015 The press pulse shall assert 3 clk edges after a btn_n high-to-low transition that is stable across sampling.
REQ-016 The FSM states and encodings shall be IDLE=0, ARMED=1, TIMING=2, DONE=3, FOUL=4, TOUT=5.
REQ-017 IDLE, DONE, FOUL, TOUT: start shall transition to ARMED, clear time_bcd to 0, and clear the tick counter.
REQ-018 ARMED: press shall transition to FOUL; else go high shall transition to TIMING.
REQ-019 ARMED: when press and go are high in the same cycle, press shall take priority and the FSM shall transition to FOUL.
REQ-020 ARMED, TIMING: start shall be ignored.
REQ-021 TIMING: a ms tick shall be a free counter reaching CLK_PER_MS-1 and wrapping to 0.
REQ-022 TIMING: the counter shall start at 0 on TIMING entry, so the first tick occurs CLK_PER_MS cycles after entry.
REQ-023 Each tick shall increment time_bcd by 1 with decimal carry across digits: 0009->0010, 0999->1000.
REQ-024 TIMING: press shall transition to DONE with time_bcd frozen.
REQ-025 TIMING: when press and a tick coincide, the press shall take priority and that tick shall not be applied.
REQ-026 TIMING: a tick that makes time_bcd equal TIMEOUT_MS shall transition to TOUT, with time_bcd holding TIMEOUT_MS.
REQ-027 TIMING: go falling shall be ignored.
REQ-028 done, foul and timeout shall each be high exactly while in DONE, FOUL and TOUT respectively, registered and one-hot-or-zero.
REQ-029 Press events in IDLE, DONE, FOUL and TOUT shall be ignored.

Reset
REQ-030 rst shall force state IDLE, time_bcd=0, done=foul=timeout=0, tick counter=0, synchronizer and edge flops=1 (released), and best_bcd=16'h9999.
REQ-031 rst shall take priority over all other inputs.
REQ-032 rst asserted mid-round shall abort the round with no status flag set.

Configuration
REQ-033 The macro is REACTION_BEST_EN.
REQ-034 With REACTION_BEST_EN defined, on each TIMING->DONE transition, if the frozen time is less than best_bcd, best_bcd shall load it in the same cycle that done rises.
REQ-035 With REACTION_BEST_EN defined, best_bcd shall be unaffected by FOUL, TOUT and start.
REQ-036 Without REACTION_BEST_EN, best_bcd shall be constant 0 and no comparison logic shall be present.

Verification (CLK_PER_MS=4, TIMEOUT_MS=20, REACTION_BEST_EN defined)
REQ-037 rst, start, go high, btn_n low 30 cycles after TIMING entry -> press at cycle ~33, done=1, time_bcd=16'h0008, best_bcd=16'h0008.
REQ-038 start, btn_n pulsed low while go=0 in ARMED -> foul=1, time_bcd=0, best_bcd unchanged.
REQ-039 start, go high, no press -> timeout=1 exactly 80 cycles after TIMING entry, time_bcd=16'h0020.
REQ-040 Press aligned to the cycle of the 3rd tick -> time_bcd=16'h0002, done=1.
REQ-041 Second round with 16'h0012 after best 16'h0008 -> best_bcd stays 16'h0008.
REQ-042 Third round with 16'h0005 after best 16'h0008 -> best_bcd=16'h0005.
REQ-043 Separate run, TIMEOUT_MS=9999: force 1100 ticks -> time_bcd=16'h1100, correct carry at 0999->1000.
REQ-044 rst asserted while in TIMING -> next cycle state IDLE, all flags 0, time_bcd=0.
